// File: rtl/int_to_chars_if.sv
// Handshake bundle for int_to_chars: value in, one ASCII digit out.
// master = producer/consumer side, slave = the converter.
interface int_to_chars_if #(
  parameter int VAL_W = 16
);
  logic             in_valid;
  logic [VAL_W-1:0] in_value;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_char;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_char,
    input  out_last, busy
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_char,
    output out_last, busy
  );
endinterface

// File: rtl/int_to_chars.sv
// Unsigned integer to ASCII decimal string, MSD first, leading zeros dropped.
// Double-dabble conversion, then one character per accepted transfer.
module int_to_chars #(
  parameter int VAL_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic          clk,
  input  logic          resetn,
  int_to_chars_if.slave io
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(VAL_W + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    EMIT
  } state_t;

  state_t           state, state_n;
  logic [BW-1:0]    bcd, bcd_n, adj;
  logic [VAL_W-1:0] value, value_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [IW-1:0]    idx, idx_n, msd;
  logic [3:0]       nib;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      bcd   <= '0;
      value <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      bcd   <= bcd_n;
      value <= value_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    adj = bcd;
    msd = '0;
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4+:4] >= 4'd5)
        adj[i*4+:4] = bcd[i*4+:4] + 4'd3;
      if (bcd[i*4+:4] != 4'd0)
        msd = IW'(i);
      if (idx == IW'(i))
        nib = bcd[i*4+:4];
    end
  end

  always_comb begin
    state_n      = state;
    bcd_n        = bcd;
    value_n      = value;
    cnt_n        = cnt;
    idx_n        = idx;
    io.in_ready  = (state == IDLE);
    io.busy      = (state != IDLE);
    io.out_valid = 1'b0;
    io.out_last  = 1'b0;
    io.out_char  = 8'd0;
    unique case (state)
      IDLE: begin
        if (io.in_valid) begin
          value_n = io.in_value;
          bcd_n   = '0;
          cnt_n   = CW'(VAL_W);
          state_n = CONVERT;
        end
      end
      CONVERT: begin
        // One extra cycle after the last shift picks the leading digit.
        if (cnt == '0) begin
          idx_n   = msd;
          state_n = EMIT;
        end else begin
          {bcd_n, value_n} = {adj, value} << 1;
          cnt_n = cnt - CW'(1);
        end
      end
      EMIT: begin
        io.out_valid = 1'b1;
        io.out_last  = (idx == '0);
        io.out_char  = 8'd48 + {4'd0, nib};
        if (io.out_ready) begin
          if (idx == '0)
            state_n = IDLE;
          else
            idx_n = idx - IW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_int_to_chars.sv
// Scoreboarded bench for int_to_chars: directed cases plus random values,
// expected strings built from plain decimal arithmetic.
module tb_int_to_chars;
  localparam int VAL_W  = 16;
  localparam int DIGITS = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int_to_chars_if #(.VAL_W(VAL_W)) io ();

  int_to_chars #(
    .VAL_W (VAL_W),
    .DIGITS(DIGITS)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .io    (io)
  );

  logic [8:0] sb[$];
  int vectors = 0;
  int miscompares = 0;
  int rmode = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic void push_model(input int unsigned v);
    int unsigned d[$];
    int unsigned t;
    t = v;
    do begin
      d.push_front(t % 10);
      t = t / 10;
    end while (t != 0);
    foreach (d[i])
      sb.push_back({(i == d.size() - 1), 8'(48 + d[i])});
  endfunction

  // out_ready pattern: 0 = always, 1 = toggling, 2 = random
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: io.out_ready = 1'b1;
        1: io.out_ready = ~io.out_ready;
        default: io.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    logic       prev_stall;
    logic [8:0] prev_out;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(io.out_valid), 32'd1);
          chk("stall_hold", 32'({io.out_last, io.out_char}),
              32'(prev_out));
        end
        if (io.out_valid && io.out_ready) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL extra_char: got %0d, want none",
                     io.out_char);
          end else begin
            e = sb.pop_front();
            chk("char", 32'(io.out_char), 32'(e[7:0]));
            chk("last", 32'(io.out_last), 32'(e[8]));
          end
        end
        prev_stall = io.out_valid && !io.out_ready;
        prev_out   = {io.out_last, io.out_char};
      end
    end
  end

  task automatic send(input logic [VAL_W-1:0] v);
    int n;
    n = 0;
    while (!io.in_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_wait_ok", 32'(n < 500), 32'd1);
    io.in_valid = 1'b1;
    io.in_value = v;
    push_model(int'(v));
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic latency(input bit inject);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
      if (inject && k == 5) begin
        io.in_valid = 1'b1;
        io.in_value = 16'd99;
      end
      if (inject && k == 7)
        io.in_valid = 1'b0;
      if (!io.out_valid)
        chk("in_ready_while_busy", 32'(io.in_ready), 32'd0);
    end while (!io.out_valid && k < 40);
    chk("first_valid_edge", 32'(k), 32'(VAL_W + 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !io.in_ready) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_ok", 32'(n < 500), 32'd1);
  endtask

  initial begin
    logic [VAL_W-1:0] v;
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VAL_W-1:0] v;
    io.in_valid = 1'b0;
    io.in_value = '0;
    #12;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_out_last", 32'(io.out_last), 32'd0);
    chk("rst_out_char", 32'(io.out_char), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_busy", 32'(io.busy), 32'd0);

    @(posedge clk);
    #1;
    resetn = 1'b1;
    rmode = 0;
    send(16'd0);
    latency(1'b0);
    @(posedge clk);
    #1;
    chk("in_ready_after_zero", 32'(io.in_ready), 32'd1);
    drain();

    send(16'd65535);
    latency(1'b0);
    drain();

    rmode = 1;
    send(16'd1207);
    latency(1'b0);
    drain();

    rmode = 0;
    send(16'd10);
    latency(1'b1);
    drain();

    send(16'd7);
    latency(1'b0);
    send(16'd300);
    latency(1'b0);
    drain();

    send(16'd4321);
    latency(1'b0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("mid_rst_busy", 32'(io.busy), 32'd0);
    chk("mid_rst_out_char", 32'(io.out_char), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      chk("post_rst_quiet", 32'(io.out_valid), 32'd0);
    end
    send(16'd5);
    latency(1'b0);
    drain();

    rmode = 2;
    repeat (30) begin
      v = VAL_W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      send(v);
      latency(1'b0);
    end
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
